// File: rtl/machine_ws.sv
// machine_ws: instruction-sequencing controller for the 8-opcode accumulator CPU.
// Walks FETCH -> DECODE -> EXEC with a memory-ready handshake, a multi-byte
// instruction fetch, SKZ skipping, halt/resume and a sticky error state.
// Optional feature: define MACHINE_TIMEOUT_EN to enable the bus-timeout watchdog
// (WAIT_MAX consecutive not-ready bus cycles -> ERR, bus_err held until reset).
module machine_ws #(
    parameter int IR_BYTES = 2,
    parameter int WAIT_MAX = 15,
    parameter int CNT_W    = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ena,
    input  logic [2:0] opcode,
    input  logic       zero,
    input  logic       mem_rdy,
    input  logic       resume,
    output logic       inc_pc,
    output logic       load_acc,
    output logic       load_pc,
    output logic       rd,
    output logic       wr,
    output logic       load_ir,
    output logic       datactl_ena,
    output logic       halt,
    output logic       bus_err
);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_SKIP, S_HALTED, S_ERR
    } state_t;

    localparam logic [2:0] OP_HLT  = 3'd0;
    localparam logic [2:0] OP_SKZ  = 3'd1;
    localparam logic [2:0] OP_ADD  = 3'd2;
    localparam logic [2:0] OP_ANDD = 3'd3;
    localparam logic [2:0] OP_XORR = 3'd4;
    localparam logic [2:0] OP_LDA  = 3'd5;
    localparam logic [2:0] OP_STO  = 3'd6;
    localparam logic [2:0] OP_JMP  = 3'd7;

    localparam logic [CNT_W-1:0] BYTE_LAST = CNT_W'(IR_BYTES - 1);

    // Reject configurations the counters cannot represent.
    if (IR_BYTES < 1 || WAIT_MAX < 1 ||
        (2 ** CNT_W) - 1 < WAIT_MAX || (2 ** CNT_W) - 1 < IR_BYTES) begin : g_bad_params
        $error("machine_ws: IR_BYTES/WAIT_MAX must be >= 1 and fit in CNT_W bits");
    end

    state_t           r_state;
    state_t           w_next_state;
    logic [CNT_W-1:0] r_bcnt;
    logic [CNT_W-1:0] w_next_bcnt;
    logic             r_rd, r_wr, r_load_ir, r_datactl_ena, r_halt, r_bus_err;

    logic w_mem_op, w_is_sto, w_is_jmp, w_is_skz, w_bus, w_last, w_timeout;

    assign w_mem_op = (opcode == OP_ADD) || (opcode == OP_ANDD) ||
                      (opcode == OP_XORR) || (opcode == OP_LDA);
    assign w_is_sto = (opcode == OP_STO);
    assign w_is_jmp = (opcode == OP_JMP);
    assign w_is_skz = (opcode == OP_SKZ);
    // Bus cycles are the ones driving rd or wr toward memory.
    assign w_bus    = (r_state == S_FETCH) ||
                      ((r_state == S_EXEC) && (w_mem_op || w_is_sto));
    assign w_last   = (r_bcnt == BYTE_LAST);

`ifdef MACHINE_TIMEOUT_EN
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(WAIT_MAX - 1);
    logic [CNT_W-1:0] r_wcnt;

    assign w_timeout = ena && w_bus && !mem_rdy && (r_wcnt == WAIT_LAST);

    // Count consecutive not-ready bus cycles; any ready or non-bus cycle restarts it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wcnt <= '0;
        end else if (ena) begin
            if (!w_bus || mem_rdy) r_wcnt <= '0;
            else                   r_wcnt <= r_wcnt + CNT_W'(1);
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    // Next-state and byte-counter decision; ena low freezes everything.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        w_next_state = r_state;
        w_next_bcnt  = r_bcnt;
        if (ena) begin
            unique case (r_state)
                S_IDLE:   w_next_state = S_FETCH;
                S_FETCH: begin
                    if (w_timeout) w_next_state = S_ERR;
                    else if (mem_rdy) begin
                        if (w_last) w_next_state = S_DECODE;
                        else        w_next_bcnt  = r_bcnt + CNT_W'(1);
                    end
                end
                S_DECODE: begin
                    w_next_bcnt  = '0;
                    w_next_state = (opcode == OP_HLT) ? S_HALTED : S_EXEC;
                end
                S_EXEC: begin
                    if (w_timeout) w_next_state = S_ERR;
                    else if (w_mem_op || w_is_sto) begin
                        if (mem_rdy) w_next_state = S_FETCH;
                    end else if (w_is_skz && zero && IR_BYTES > 1) begin
                        w_next_state = S_SKIP;
                        w_next_bcnt  = CNT_W'(1);
                    end else begin
                        w_next_state = S_FETCH;
                    end
                end
                S_SKIP: begin
                    if (w_last) w_next_state = S_FETCH;
                    else        w_next_bcnt  = r_bcnt + CNT_W'(1);
                end
                S_HALTED: if (resume) w_next_state = S_FETCH;
                S_ERR:    w_next_state = S_ERR;
                default:  w_next_state = S_IDLE;
            endcase
            if (w_next_state == S_FETCH && r_state != S_FETCH) w_next_bcnt = '0;
        end
    end

    // State, counter and level outputs; levels are decoded from the state being entered.
    always_ff @(posedge clk or negedge reset) begin
        // NOTE: async reset clears state and outputs at once, so rd/wr drop mid-access.
        if (!reset) begin
            r_state       <= S_IDLE;
            r_bcnt        <= '0;
            r_rd          <= 1'b0;
            r_wr          <= 1'b0;
            r_load_ir     <= 1'b0;
            r_datactl_ena <= 1'b0;
            r_halt        <= 1'b0;
            r_bus_err     <= 1'b0;
        end else begin
            // NOTE: registers use non-blocking assignment so every flop samples pre-edge values.
            r_state       <= w_next_state;
            r_bcnt        <= w_next_bcnt;
            r_rd          <= (w_next_state == S_FETCH) || ((w_next_state == S_EXEC) && w_mem_op);
            r_wr          <= (w_next_state == S_EXEC) && w_is_sto;
            r_datactl_ena <= (w_next_state == S_EXEC) && w_is_sto;
            r_load_ir     <= (w_next_state == S_FETCH);
            r_halt        <= (w_next_state == S_HALTED);
            r_bus_err     <= (w_next_state == S_ERR);
        end
    end

    assign rd          = r_rd;
    assign wr          = r_wr;
    assign load_ir     = r_load_ir;
    assign datactl_ena = r_datactl_ena;
    assign halt        = r_halt;
    assign bus_err     = r_bus_err;

    // One-cycle strobes, combinational so they can react to mem_rdy in the same cycle.
    assign inc_pc   = ena && (((r_state == S_FETCH) && mem_rdy) ||
                              ((r_state == S_EXEC) && w_is_skz && zero) ||
                              (r_state == S_SKIP));
    assign load_acc = ena && (r_state == S_EXEC) && w_mem_op && mem_rdy;
    assign load_pc  = ena && (r_state == S_EXEC) && w_is_jmp;

endmodule
